multiplicador_serie: RTL



---
 rtl/multiplicador_serie_pkg.sv | 37 +++
 rtl/booth_paso.sv | 26 ++
 rtl/multiplicador_serie.sv | 93 +++++++++
 3 files changed

// File: rtl/multiplicador_serie_pkg.sv
// Shared widths, state encoding and result packing for the serial Booth multiplier.
// MULT_SAT_EN: when defined, an overflowing product saturates to PROD_MAX instead of wrapping.
package multiplicador_serie_pkg;

  localparam int unsigned W  = 6;
  localparam int unsigned PW = 2*W - 1;
  localparam int unsigned AW = 2*W + 2;
  localparam int unsigned CW = $clog2(W);

  // Bounds shared with the downstream rounding stage
  localparam logic [PW-1:0] PROD_MIN = {1'b1, {(PW-1){1'b0}}};
  localparam logic [PW-1:0] PROD_MAX = ~PROD_MIN;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  typedef struct packed {
    logic          ovf;
    logic [PW-1:0] product;
  } mult_res_t;

  // Drop the redundant sign bit of the Q4.6 result; flag when it is not redundant
  function automatic mult_res_t pack_result(input logic [2*W-1:0] full);
    mult_res_t r;
    r.ovf = full[2*W-1] ^ full[2*W-2];
`ifdef MULT_SAT_EN
    r.product = r.ovf ? PROD_MAX : full[PW-1:0];
`else
    r.product = full[PW-1:0];
`endif
    return r;
  endfunction

endpackage

// File: rtl/booth_paso.sv
// One radix-2 Booth step: conditional add/sub of the multiplicand into the upper half, then arithmetic shift.
module booth_paso
  import multiplicador_serie_pkg::*;
(
  input  logic [AW-1:0] acc,
  input  logic [W-1:0]  a,
  output logic [AW-1:0] acc_nx
);

  logic [W:0] hi;
  logic [W:0] a_ext;
  logic [W:0] sum;

  always_comb begin
    hi    = acc[AW-1:W+1];
    a_ext = {a[W-1], a};
    sum   = hi;
    case (acc[1:0])
      2'b01:   sum = hi + a_ext;
      2'b10:   sum = hi - a_ext;
      default: sum = hi;
    endcase
    acc_nx = {sum[W], sum, acc[W:1]};
  end

endmodule

// File: rtl/multiplicador_serie.sv
// Serial signed Q2.3 x Q2.3 Booth multiplier with start/done handshake, W+1 cycle latency.
// MULT_SAT_EN (see package): saturate product on overflow instead of wrapping.
module multiplicador_serie
  import multiplicador_serie_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          busy,
  output logic          done,
  output logic [PW-1:0] product,
  output logic          ovf
);

  state_t        state, state_nx;
  logic [AW-1:0] acc, acc_nx, acc_step;
  logic [W-1:0]  a_q, a_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          busy_nx, done_nx, ovf_nx;
  logic [PW-1:0] prod_nx;
  mult_res_t     res;

  booth_paso u_paso (
    .acc    (acc),
    .a      (a_q),
    .acc_nx (acc_step)
  );

  // Result as it will stand after the final step
  assign res = pack_result(acc_step[2*W:1]);

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    a_nx     = a_q;
    cnt_nx   = cnt;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    prod_nx  = product;
    ovf_nx   = ovf;
    case (state)
      ST_IDLE, ST_FIN: begin
        if (start) begin
          state_nx = ST_CALC;
          acc_nx   = {(W+1)'(0), b, 1'b0};
          a_nx     = a;
          cnt_nx   = '0;
          busy_nx  = 1'b1;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_CALC: begin
        acc_nx = acc_step;
        cnt_nx = cnt + CW'(1);
        if (cnt == CW'(W-1)) begin
          state_nx = ST_FIN;
          done_nx  = 1'b1;
          prod_nx  = res.product;
          ovf_nx   = res.ovf;
        end else begin
          busy_nx  = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      acc     <= '0;
      a_q     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_nx;
      acc     <= acc_nx;
      a_q     <= a_nx;
      cnt     <= cnt_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      product <= prod_nx;
      ovf     <= ovf_nx;
    end
  end

endmodule
